// File: rtl/s_axi_write_response_gather_3to1_pkg.sv
// Shared constants for the 3-to-1 SLR write-response gather block.
package s_axi_write_response_gather_3to1_pkg;

    localparam int NUM_SLR = 3;

    // AXI BRESP encodings, ordered so that a larger code is a worse outcome
    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    // Worst-of-two response; relies on the numeric ordering of the encodings
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/s_axi_write_response_gather_3to1_if.sv
// B-channel bundle: three per-SLR response inputs, one merged host output.
interface s_axi_write_response_gather_3to1_if;

    logic       s_axi_control_BVALID_slr_0;
    logic       s_axi_control_BVALID_slr_1;
    logic       s_axi_control_BVALID_slr_2;
    logic       s_axi_control_BREADY_slr_0;
    logic       s_axi_control_BREADY_slr_1;
    logic       s_axi_control_BREADY_slr_2;
    logic [1:0] s_axi_control_BRESP_slr_0;
    logic [1:0] s_axi_control_BRESP_slr_1;
    logic [1:0] s_axi_control_BRESP_slr_2;
    logic       s_axi_control_BVALID;
    logic       s_axi_control_BREADY;
    logic [1:0] s_axi_control_BRESP;
    logic       resp_mismatch;

    // Gather block's view
    modport slave (
        input  s_axi_control_BVALID_slr_0, s_axi_control_BVALID_slr_1, s_axi_control_BVALID_slr_2,
        input  s_axi_control_BRESP_slr_0, s_axi_control_BRESP_slr_1, s_axi_control_BRESP_slr_2,
        output s_axi_control_BREADY_slr_0, s_axi_control_BREADY_slr_1, s_axi_control_BREADY_slr_2,
        output s_axi_control_BVALID, s_axi_control_BRESP, resp_mismatch,
        input  s_axi_control_BREADY
    );

    // SLR/host side view
    modport master (
        output s_axi_control_BVALID_slr_0, s_axi_control_BVALID_slr_1, s_axi_control_BVALID_slr_2,
        output s_axi_control_BRESP_slr_0, s_axi_control_BRESP_slr_1, s_axi_control_BRESP_slr_2,
        input  s_axi_control_BREADY_slr_0, s_axi_control_BREADY_slr_1, s_axi_control_BREADY_slr_2,
        input  s_axi_control_BVALID, s_axi_control_BRESP, resp_mismatch,
        output s_axi_control_BREADY
    );

endinterface

// File: rtl/s_axi_write_response_gather_3to1_resp_fifo.sv
// Per-SLR response buffer: DEPTH x 2-bit FIFO with registered occupancy and ready.
module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [1:0] i_data,
    output logic       o_ready,
    input  logic       i_pop,
    output logic [1:0] o_head,
    output logic       o_nempty
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    // Ready is a register, so a full FIFO refuses a push even while it is being popped
    assign w_push = i_valid & r_ready;
    assign w_pop  = i_pop & (r_count != '0);

    // Next occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and ready; ready held low while in reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != FULL);
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_ready  = r_ready;
    assign o_head   = r_mem[r_rptr];
    assign o_nempty = (r_count != '0);

endmodule

// File: rtl/s_axi_write_response_gather_3to1.sv
// Gathers one B response from each of three SLRs into a single host response.
module s_axi_write_response_gather_3to1
    import s_axi_write_response_gather_3to1_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                                ap_clk,
    input  logic                                reset,
    s_axi_write_response_gather_3to1_if.slave   bus
);

    logic [NUM_SLR-1:0]       w_slr_valid;
    logic [NUM_SLR-1:0]       w_slr_ready;
    logic [NUM_SLR-1:0][1:0]  w_slr_resp;
    logic [NUM_SLR-1:0][1:0]  w_head;
    logic [NUM_SLR-1:0]       w_nempty;
    logic                     w_bvalid;
    logic [1:0]               w_bresp;
    logic                     w_pop;
    logic                     w_heads_differ;
    logic                     r_mismatch;

    assign w_slr_valid = {bus.s_axi_control_BVALID_slr_2,
                          bus.s_axi_control_BVALID_slr_1,
                          bus.s_axi_control_BVALID_slr_0};
    assign w_slr_resp  = {bus.s_axi_control_BRESP_slr_2,
                          bus.s_axi_control_BRESP_slr_1,
                          bus.s_axi_control_BRESP_slr_0};

    assign bus.s_axi_control_BREADY_slr_0 = w_slr_ready[0];
    assign bus.s_axi_control_BREADY_slr_1 = w_slr_ready[1];
    assign bus.s_axi_control_BREADY_slr_2 = w_slr_ready[2];

    // One buffer per SLR, all popped by the same merged handshake
    for (genvar g = 0; g < NUM_SLR; g++) begin : g_slr
        resp_fifo #(
            .DEPTH (FIFO_DEPTH),
            .AW    (FIFO_AW)
        ) u_fifo (
            .i_clk    (ap_clk),
            .i_rst    (reset),
            .i_valid  (w_slr_valid[g]),
            .i_data   (w_slr_resp[g]),
            .o_ready  (w_slr_ready[g]),
            .i_pop    (w_pop),
            .o_head   (w_head[g]),
            .o_nempty (w_nempty[g])
        );
    end

    // Merged response exists only once every SLR has answered; report the worst code
    assign w_bvalid       = &w_nempty;
    assign w_bresp        = resp_max(resp_max(w_head[0], w_head[1]), w_head[2]);
    assign w_pop          = w_bvalid & bus.s_axi_control_BREADY;
    assign w_heads_differ = (w_head[0] != w_head[1]) | (w_head[1] != w_head[2]);

    // Sticky flag for any popped triple whose SLR codes disagree
    always_ff @(posedge ap_clk) begin
        if (reset) r_mismatch <= 1'b0;
        else if (w_pop && w_heads_differ) r_mismatch <= 1'b1;
    end

    assign bus.s_axi_control_BVALID = w_bvalid;
    assign bus.s_axi_control_BRESP  = w_bresp;
    assign bus.resp_mismatch        = r_mismatch;

endmodule

// File: tb/tb_s_axi_write_response_gather_3to1.sv
// Directed bench for the 3-to-1 write-response gather.
module tb_s_axi_write_response_gather_3to1;

    logic ap_clk = 1'b0;
    logic reset  = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    s_axi_write_response_gather_3to1_if ifc();

    s_axi_write_response_gather_3to1 #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .ap_clk (ap_clk),
        .reset  (reset),
        .bus    (ifc.slave)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs set after this return apply to the next edge
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle_in();
        ifc.s_axi_control_BVALID_slr_0 = 1'b0;
        ifc.s_axi_control_BVALID_slr_1 = 1'b0;
        ifc.s_axi_control_BVALID_slr_2 = 1'b0;
        ifc.s_axi_control_BRESP_slr_0  = 2'd0;
        ifc.s_axi_control_BRESP_slr_1  = 2'd0;
        ifc.s_axi_control_BRESP_slr_2  = 2'd0;
    endtask

    task automatic do_reset();
        idle_in();
        ifc.s_axi_control_BREADY = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    logic [1:0] seq2 [5];
    int         hi_cnt;
    int         first_hi;
    logic       gap;

    initial begin
        idle_in();
        ifc.s_axi_control_BREADY = 1'b0;
        seq2[0] = 2'd1; seq2[1] = 2'd2; seq2[2] = 2'd0; seq2[3] = 2'd1; seq2[4] = 2'd3;

        // Reset state
        tick();
        tick();
        chk("rst_bvalid", 32'(ifc.s_axi_control_BVALID), 0);
        chk("rst_bready_slr", {29'd0, ifc.s_axi_control_BREADY_slr_2,
            ifc.s_axi_control_BREADY_slr_1, ifc.s_axi_control_BREADY_slr_0}, 0);
        chk("rst_mismatch", 32'(ifc.resp_mismatch), 0);
        reset = 1'b0;
        tick();
        chk("post_rst_bready_slr", {29'd0, ifc.s_axi_control_BREADY_slr_2,
            ifc.s_axi_control_BREADY_slr_1, ifc.s_axi_control_BREADY_slr_0}, 3'b111);

        // Staggered OKAYs: merged valid appears one edge after the last SLR answers
        ifc.s_axi_control_BREADY = 1'b1;
        ifc.s_axi_control_BVALID_slr_0 = 1'b1; tick(); ifc.s_axi_control_BVALID_slr_0 = 1'b0;
        tick();
        ifc.s_axi_control_BVALID_slr_1 = 1'b1; tick(); ifc.s_axi_control_BVALID_slr_1 = 1'b0;
        chk("stagger_wait_bvalid", 32'(ifc.s_axi_control_BVALID), 0);
        tick(); tick(); tick();
        ifc.s_axi_control_BVALID_slr_2 = 1'b1; tick(); ifc.s_axi_control_BVALID_slr_2 = 1'b0;
        chk("stagger_bvalid", 32'(ifc.s_axi_control_BVALID), 1);
        chk("stagger_bresp", 32'(ifc.s_axi_control_BRESP), 0);
        tick();
        chk("stagger_single", 32'(ifc.s_axi_control_BVALID), 0);
        chk("stagger_mismatch", 32'(ifc.resp_mismatch), 0);

        // Differing codes: worst wins, sticky flag after the pop
        ifc.s_axi_control_BREADY = 1'b0;
        ifc.s_axi_control_BVALID_slr_0 = 1'b1; ifc.s_axi_control_BRESP_slr_0 = 2'd0;
        ifc.s_axi_control_BVALID_slr_1 = 1'b1; ifc.s_axi_control_BRESP_slr_1 = 2'd2;
        ifc.s_axi_control_BVALID_slr_2 = 1'b1; ifc.s_axi_control_BRESP_slr_2 = 2'd0;
        tick();
        idle_in();
        chk("mix_bresp", 32'(ifc.s_axi_control_BRESP), 2);
        chk("mix_no_flag_before_pop", 32'(ifc.resp_mismatch), 0);
        tick();
        chk("mix_hold_bvalid", 32'(ifc.s_axi_control_BVALID), 1);
        chk("mix_hold_bresp", 32'(ifc.s_axi_control_BRESP), 2);
        ifc.s_axi_control_BREADY = 1'b1;
        tick();
        chk("mix_popped", 32'(ifc.s_axi_control_BVALID), 0);
        chk("mix_flag", 32'(ifc.resp_mismatch), 1);
        for (int i = 0; i < 20; i++) tick();
        chk("mix_flag_held", 32'(ifc.resp_mismatch), 1);

        // Backpressure on SLR0: four accepted, fifth waits for a pop
        do_reset();
        chk("reset_clears_flag", 32'(ifc.resp_mismatch), 0);
        ifc.s_axi_control_BVALID_slr_0 = 1'b1; ifc.s_axi_control_BRESP_slr_0 = 2'd1;
        tick(); tick(); tick();
        chk("bp_ready_at3", 32'(ifc.s_axi_control_BREADY_slr_0), 1);
        tick();
        chk("bp_full_after4", 32'(ifc.s_axi_control_BREADY_slr_0), 0);
        tick();
        chk("bp_still_full", 32'(ifc.s_axi_control_BREADY_slr_0), 0);
        ifc.s_axi_control_BVALID_slr_1 = 1'b1;
        ifc.s_axi_control_BVALID_slr_2 = 1'b1;
        tick();
        ifc.s_axi_control_BVALID_slr_1 = 1'b0;
        ifc.s_axi_control_BVALID_slr_2 = 1'b0;
        chk("bp_bvalid", 32'(ifc.s_axi_control_BVALID), 1);
        chk("bp_bresp", 32'(ifc.s_axi_control_BRESP), 1);
        ifc.s_axi_control_BREADY = 1'b1;
        tick();
        chk("bp_pop_frees", 32'(ifc.s_axi_control_BREADY_slr_0), 1);
        chk("bp_pop_bvalid", 32'(ifc.s_axi_control_BVALID), 0);
        tick();
        chk("bp_fifth_taken", 32'(ifc.s_axi_control_BREADY_slr_0), 0);
        idle_in();

        // Streaming: one merged response per cycle
        do_reset();
        ifc.s_axi_control_BREADY = 1'b1;
        ifc.s_axi_control_BVALID_slr_0 = 1'b1;
        ifc.s_axi_control_BVALID_slr_1 = 1'b1;
        ifc.s_axi_control_BVALID_slr_2 = 1'b1;
        hi_cnt = 0; first_hi = -1; gap = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 16) idle_in();
            if (ifc.s_axi_control_BVALID === 1'b1) begin
                if (first_hi < 0) first_hi = i;
                if (hi_cnt != i - first_hi) gap = 1'b1;
                hi_cnt++;
            end
        end
        chk("stream_first", 32'(first_hi), 1);
        chk("stream_count", 32'(hi_cnt), 16);
        chk("stream_gapless", 32'(gap), 0);
        chk("stream_drained", 32'(ifc.s_axi_control_BVALID), 0);

        // Reset mid-operation discards partial fills
        do_reset();
        ifc.s_axi_control_BVALID_slr_0 = 1'b1;
        ifc.s_axi_control_BVALID_slr_1 = 1'b1;
        tick(); tick();
        idle_in();
        chk("part_no_bvalid", 32'(ifc.s_axi_control_BVALID), 0);
        reset = 1'b1;
        tick();
        chk("part_rst_bvalid", 32'(ifc.s_axi_control_BVALID), 0);
        chk("part_rst_bready", {29'd0, ifc.s_axi_control_BREADY_slr_2,
            ifc.s_axi_control_BREADY_slr_1, ifc.s_axi_control_BREADY_slr_0}, 0);
        reset = 1'b0;
        tick();
        ifc.s_axi_control_BVALID_slr_2 = 1'b1;
        tick();
        idle_in();
        chk("part_discarded", 32'(ifc.s_axi_control_BVALID), 0);

        // SLR2 full, pop and push in the same cycle, then pointer wrap check
        do_reset();
        ifc.s_axi_control_BVALID_slr_2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifc.s_axi_control_BRESP_slr_2 = seq2[i];
            tick();
        end
        chk("full_slr2", 32'(ifc.s_axi_control_BREADY_slr_2), 0);
        ifc.s_axi_control_BRESP_slr_2 = seq2[4];
        ifc.s_axi_control_BVALID_slr_0 = 1'b1;
        ifc.s_axi_control_BVALID_slr_1 = 1'b1;
        tick();
        ifc.s_axi_control_BVALID_slr_0 = 1'b0;
        ifc.s_axi_control_BVALID_slr_1 = 1'b0;
        chk("full_head", 32'(ifc.s_axi_control_BRESP), 32'(seq2[0]));
        ifc.s_axi_control_BREADY = 1'b1;
        tick();
        chk("full_pop_done", 32'(ifc.s_axi_control_BVALID), 0);
        chk("full_push_refused", 32'(ifc.s_axi_control_BREADY_slr_2), 1);
        tick();
        ifc.s_axi_control_BVALID_slr_2 = 1'b0;
        chk("full_push_next", 32'(ifc.s_axi_control_BREADY_slr_2), 0);
        ifc.s_axi_control_BVALID_slr_0 = 1'b1;
        ifc.s_axi_control_BVALID_slr_1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("wrap_head%0d", i), 32'(ifc.s_axi_control_BRESP), 32'(seq2[i]));
        end
        idle_in();
        tick();
        chk("wrap_empty", 32'(ifc.s_axi_control_BVALID), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/s_axi_write_response_gather_3to1.md
S_AXI_WRITE_RESPONSE_GATHER_3TO1 -- requirements
Module: s_axi_write_response_gather_3to1

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, per-SLR response buffer depth (power of two, >=2).
REQ-002 SHALL have parameter FIFO_AW, default 2, log2(FIFO_DEPTH).
REQ-003 SHALL have port ap_clk, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports s_axi_control_BVALID_slr_k, input, 1: per-SLR response valid, for k=0,1,2.
REQ-006 SHALL have ports s_axi_control_BREADY_slr_k, output, 1: per-SLR response ready, for k=0,1,2.
REQ-007 SHALL have ports s_axi_control_BRESP_slr_k, input, 2: per-SLR response code, for k=0,1,2.
REQ-008 SHALL have port s_axi_control_BVALID, output, 1: merged response valid to host.
REQ-009 SHALL have port s_axi_control_BREADY, input, 1: host ready.
REQ-010 SHALL have port s_axi_control_BRESP, output, 2: merged response code.
REQ-011 SHALL have port resp_mismatch, output, 1: sticky flag, set when popped SLR codes differ.

Function
REQ-012 SHALL keep one FIFO per SLR, FIFO_DEPTH entries x 2 bits, with a registered occupancy count of FIFO_AW+1 bits.
REQ-013 SHALL drive BREADY_slr_k = (count_k != FIFO_DEPTH), from registers only, with no combinational path from any input.
REQ-014 SHALL push BRESP_slr_k on BVALID_slr_k & BREADY_slr_k; no push when full, even if a pop occurs in the same cycle.
REQ-015 SHALL drive s_axi_control_BVALID = (count_0!=0)&(count_1!=0)&(count_2!=0).
REQ-016 SHALL drive s_axi_control_BRESP = numeric max of the three FIFO heads (DECERR 3 > SLVERR 2 > EXOKAY 1 > OKAY 0).
REQ-017 SHALL pop all three FIFOs together on s_axi_control_BVALID & s_axi_control_BREADY, and never pop a subset.
REQ-018 SHALL, on push and pop in the same cycle on one FIFO, leave its count unchanged and store the new data correctly.
REQ-019 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-020 SHALL give latency of one cycle: a push to the last empty FIFO at edge N makes BVALID high after edge N.
REQ-021 SHALL hold BVALID and BRESP stable while BREADY is low.
REQ-022 SHALL set resp_mismatch on a pop whose three heads are not all equal, and hold it until reset.
REQ-023 SHALL support sustained throughput of one merged response per cycle when all SLRs stream and BREADY=1.

Reset
REQ-024 SHALL, when reset is sampled high, clear all counts and pointers and clear resp_mismatch.
REQ-025 SHALL hold outputs during reset at BVALID=0 and BREADY_slr_k=0; BREADY_slr_k goes to 1 on the first cycle after reset deasserts.
REQ-026 SHALL, on reset mid-operation, discard buffered responses with no partial pop; FIFO storage contents need not be cleared.

Structure
REQ-027 SHALL place the AXI BRESP encodings (OKAY, EXOKAY, SLVERR, DECERR) and the SLR count constant 3 in the shared package.
REQ-028 SHALL implement the per-SLR buffer as one sub-module, resp_fifo, instantiated three times; merge, pop and flag logic stay in the top.

Verification
REQ-029 Scenario: reset, then each SLR returns OKAY in cycles 3, 5 and 9 -> single BVALID from cycle 10, BRESP=0, resp_mismatch=0.
REQ-030 Scenario: SLR0=OKAY, SLR1=SLVERR, SLR2=OKAY with BREADY=1 -> BRESP=2, resp_mismatch=1 after the pop and held for 20 cycles.
REQ-031 Scenario: BREADY=0, SLR0 sends 5 responses -> BREADY_slr_0 drops after the 4th accept, and the 5th is held until a pop.
REQ-032 Scenario: all SLRs stream 16 OKAYs back-to-back with BREADY=1 -> 16 merged responses in 16 consecutive cycles after a 1-cycle fill latency.
REQ-033 Scenario: SLR0 and SLR1 each hold 2 entries, SLR2 holds 0, then reset is asserted -> counts cleared, BVALID=0, no response emitted.
REQ-034 Scenario: SLR2 full, pop and push offered in the same cycle -> pop completes, push is refused, and the push is accepted in the next cycle.
